// File: rtl/nfifo_rr_pkg.sv
`default_nettype none
// ============================================================================
// nfifo_rr_pkg : shared widths, depth rule and record types for nfifo_rr_reader
// Revision     : 1.0
// ============================================================================
package nfifo_rr_pkg;

  localparam int NFR_DATA_WIDTH = 64;
  localparam int NFR_FLOWS      = 4;
  localparam int NFR_LATENCY    = 1;
  localparam int NFR_FW         = $clog2(NFR_FLOWS);

  // Two spare slots on top of the read latency give back-to-back reads at 1 word/cycle.
  function automatic int nfr_depth(input int latency);
    return latency + 2;
  endfunction

  typedef struct packed {
    logic              vld;
    logic [NFR_FW-1:0] flow;
  } nfr_tag_t;

  typedef struct packed {
    logic [NFR_DATA_WIDTH-1:0] data;
    logic [NFR_FW-1:0]         flow;
  } nfr_entry_t;

endpackage
`default_nettype wire

// File: rtl/nfifo_rr_outbuf.sv
`default_nettype none
// ============================================================================
// nfifo_rr_outbuf : DEPTH-entry synchronous FIFO holding flow-tagged read words
// Revision        : 1.0
// ============================================================================
module nfifo_rr_outbuf
  import nfifo_rr_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  nfr_entry_t                   push_entry,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output nfr_entry_t                   head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  nfr_entry_t    mem_q [DEPTH];
  nfr_entry_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/nfifo_rr_reader.sv
`default_nettype none
// ============================================================================
// nfifo_rr_reader : round-robin read controller for the nfifo2fifo buffer
//                   (define NFIFO_RR_ASSERT_EN to compile in protocol checks)
// Revision        : 1.0
// ============================================================================
module nfifo_rr_reader
  import nfifo_rr_pkg::*;
#(
  parameter int DATA_WIDTH = NFR_DATA_WIDTH,
  parameter int FLOWS      = NFR_FLOWS,
  parameter int LATENCY    = NFR_LATENCY
) (
  input  logic                      CLK,
  input  logic                      RESET,
  output logic [$clog2(FLOWS)-1:0]  RD_BLOCK_ADDR,
  output logic                      RD_READ,
  input  logic [FLOWS-1:0]          RD_EMPTY,
  input  logic [DATA_WIDTH-1:0]     RD_DATA_IN,
  input  logic                      RD_DATA_VLD,
  output logic [DATA_WIDTH-1:0]     TX_DATA,
  output logic [$clog2(FLOWS)-1:0]  TX_FLOW,
  output logic                      TX_SRC_RDY,
  input  logic                      TX_DST_RDY
);

  localparam int FW    = $clog2(FLOWS);
  localparam int DEPTH = nfr_depth(LATENCY);
  localparam int OW    = $clog2(DEPTH + 1);

  logic [FW-1:0] last_q, last_d;
  nfr_tag_t      tag_q [LATENCY];
  nfr_tag_t      tag_d [LATENCY];
  logic [FW-1:0] grant;
  logic [FW-1:0] idx;
  logic          any_ready;
  logic [OW:0]   busy;
  logic [OW-1:0] occ;
  logic          rd_read;
  logic          push;
  logic          pop;
  nfr_entry_t    push_entry;
  nfr_entry_t    head_entry;

  // Descending scan so the nearest non-empty flow after LAST overwrites the rest.
  always_comb begin
    grant     = last_q;
    any_ready = 1'b0;
    idx       = '0;
    for (int i = FLOWS; i >= 1; i--) begin
      idx = last_q + FW'(i);
      if (!RD_EMPTY[idx]) begin
        grant     = idx;
        any_ready = 1'b1;
      end
    end
  end

  always_comb begin
    busy = {1'b0, occ};
    for (int s = 0; s < LATENCY; s++) begin
      busy = busy + {{OW{1'b0}}, tag_q[s].vld};
    end
  end

  assign rd_read = RESET && any_ready && (busy < (OW+1)'(DEPTH));

  always_comb begin
    tag_d[0] = '{vld: rd_read, flow: grant};
    for (int s = 1; s < LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    last_d = rd_read ? grant : last_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      last_q <= FW'(FLOWS - 1);
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      last_q <= last_d;
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign push       = tag_q[LATENCY-1].vld;
  assign push_entry = '{data: RD_DATA_IN, flow: tag_q[LATENCY-1].flow};
  assign pop        = RESET && (occ != '0) && TX_DST_RDY;

  nfifo_rr_outbuf #(
    .DEPTH (DEPTH)
  ) u_outbuf (
    .clk        (CLK),
    .rst_n      (RESET),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .occ        (occ),
    .head       (head_entry)
  );

  assign RD_READ       = rd_read;
  assign RD_BLOCK_ADDR = !RESET ? '0 : (rd_read ? grant : last_q);
  assign TX_SRC_RDY    = RESET && (occ != '0);
  assign TX_DATA       = RESET ? head_entry.data : '0;
  assign TX_FLOW       = RESET ? head_entry.flow : '0;

`ifdef NFIFO_RR_ASSERT_EN
  logic [31:0] cycle_q, cycle_d;

  always_comb cycle_d = cycle_q + 32'd1;

  always_ff @(posedge CLK) begin
    if (!RESET) cycle_q <= '0;
    else        cycle_q <= cycle_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_vld_tag: assert (RD_DATA_VLD == tag_q[LATENCY-1].vld)
        else $error("nfifo_rr_reader: RD_DATA_VLD disagrees with head tag, cycle %0d", cycle_q);
      a_occ_max: assert (occ <= OW'(DEPTH))
        else $error("nfifo_rr_reader: occupancy above depth, cycle %0d", cycle_q);
      a_rd_nonempty: assert (!(rd_read && RD_EMPTY[grant]))
        else $error("nfifo_rr_reader: read issued to empty flow, cycle %0d", cycle_q);
    end
  end

  a_tx_stable: assert property (@(posedge CLK) disable iff (!RESET)
      (TX_SRC_RDY && !TX_DST_RDY) |=> (TX_DATA == $past(TX_DATA) && TX_FLOW == $past(TX_FLOW)))
    else $error("nfifo_rr_reader: TX word changed while stalled, cycle %0d", cycle_q);
`else
  logic vld_unused;
  assign vld_unused = RD_DATA_VLD;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nfifo_rr_reader.sv
`default_nettype none
// ============================================================================
// tb_nfifo_rr_reader : two DUTs (LATENCY 1 and 2) against a queue-based model
// Revision           : 1.0
// ============================================================================
module tb_nfifo_rr_reader;
  import nfifo_rr_pkg::*;

  localparam int DW    = 64;
  localparam int FLOWS = 4;
  localparam int FW    = 2;

  typedef struct {
    int             flow;
    logic [DW-1:0]  data;
    int             due;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  logic dst_rdy;
  int   refill [FLOWS];
  int   phase;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input int f, input int n);
    return {8'hA5, 8'(f), 16'(n), 32'(n * 32'h9E37_79B1 + f * 32'h85EB_CA6B)};
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      for (int f = 0; f < FLOWS; f++) refill[f] = 0;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int LAT = g + 1;
    localparam int DEP = LAT + 2;

    logic [FW-1:0]    rd_addr;
    logic             rd_read;
    logic [FLOWS-1:0] rd_empty = '1;
    logic [DW-1:0]    rd_data  = '0;
    logic             rd_vld   = 1'b0;
    logic [DW-1:0]    tx_data;
    logic [FW-1:0]    tx_flow;
    logic             tx_src;
    int               bp_reads = 0;

    nfifo_rr_reader #(
      .DATA_WIDTH (DW),
      .FLOWS      (FLOWS),
      .LATENCY    (LAT)
    ) u_dut (
      .CLK           (clk),
      .RESET         (rst_n),
      .RD_BLOCK_ADDR (rd_addr),
      .RD_READ       (rd_read),
      .RD_EMPTY      (rd_empty),
      .RD_DATA_IN    (rd_data),
      .RD_DATA_VLD   (rd_vld),
      .TX_DATA       (tx_data),
      .TX_FLOW       (tx_flow),
      .TX_SRC_RDY    (tx_src),
      .TX_DST_RDY    (dst_rdy)
    );

    initial begin : p_env
      int    avail  [FLOWS];
      int    up_idx [FLOWS];
      int    m_idx  [FLOWS];
      item_t ret  [$];
      item_t pend [$];
      item_t q    [$];
      item_t it;
      int    cyc, last, r_addr, m_grant, f;
      bit    r_rst, r_dst, r_read, m_read, m_src, any;
      string pfx;

      pfx = $sformatf("L%0d", LAT);
      for (int k = 0; k < FLOWS; k++) begin
        avail[k] = 0; up_idx[k] = 0; m_idx[k] = 0;
      end
      cyc = 0; last = FLOWS - 1; r_addr = 0; m_grant = 0;
      r_rst = 0; r_dst = 0; r_read = 0; m_read = 0; m_src = 0;

      forever begin
        @(posedge clk);
        #1;
        cyc++;
        // upstream buffer: registered empties, memory answering after LAT cycles
        if (r_read && avail[r_addr] > 0) begin
          avail[r_addr]--;
          ret.push_back('{r_addr, word_of(r_addr, up_idx[r_addr]), cyc - 1 + LAT});
          up_idx[r_addr]++;
        end
        for (int k = 0; k < FLOWS; k++) begin
          avail[k]    += refill[k];
          rd_empty[k]  = (avail[k] == 0);
        end
        rd_vld  = 1'b0;
        rd_data = {$urandom, $urandom};
        if (ret.size() > 0 && ret[0].due == cyc) begin
          it      = ret.pop_front();
          rd_vld  = 1'b1;
          rd_data = it.data;
        end

        // reference model update for the cycle that just ended
        if (!r_rst) begin
          pend.delete();
          q.delete();
          last = FLOWS - 1;
        end else begin
          if (m_src && r_dst) void'(q.pop_front());
          while (pend.size() > 0 && pend[0].due == cyc - 1) q.push_back(pend.pop_front());
          if (m_read) begin
            pend.push_back('{m_grant, word_of(m_grant, m_idx[m_grant]), cyc - 1 + LAT});
            m_idx[m_grant]++;
            last = m_grant;
          end
        end

        @(negedge clk);
        r_rst = rst_n;
        r_dst = dst_rdy;
        if (!rst_n) begin
          m_read = 0;
          m_src  = 0;
          check_eq({pfx, " rst rd_read"}, 64'(rd_read), 64'(0));
          check_eq({pfx, " rst rd_addr"}, 64'(rd_addr), 64'(0));
          check_eq({pfx, " rst tx_src"},  64'(tx_src),  64'(0));
          check_eq({pfx, " rst tx_flow"}, 64'(tx_flow), 64'(0));
          check_eq({pfx, " rst tx_data"}, tx_data, 64'(0));
        end else begin
          any     = 0;
          m_grant = last;
          for (int i = 1; i <= FLOWS && !any; i++) begin
            f = (last + i) % FLOWS;
            if (!rd_empty[f]) begin
              m_grant = f;
              any     = 1;
            end
          end
          m_read = any && (q.size() + pend.size() < DEP);
          m_src  = (q.size() > 0);
          check_eq({pfx, " rd_read"}, 64'(rd_read), 64'(m_read));
          check_eq({pfx, " rd_addr"}, 64'(rd_addr), 64'(m_read ? m_grant : last));
          check_eq({pfx, " tx_src"},  64'(tx_src),  64'(m_src));
          if (m_src) begin
            check_eq({pfx, " tx_flow"}, 64'(tx_flow), 64'(q[0].flow));
            check_eq({pfx, " tx_data"}, tx_data, q[0].data);
          end
        end
        r_read = rd_read;
        r_addr = int'(rd_addr);
        if (phase == 2 && rd_read) bp_reads++;
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    dst_rdy = 1'b1;
    phase   = 0;
    for (int k = 0; k < FLOWS; k++) refill[k] = 6;
    step(3);
    rst_n = 1'b1;
    step(30);

    // single flow with three words
    refill[2] = 3;
    step(12);

    // backpressure from empty: exactly DEPTH reads per instance
    dst_rdy = 1'b0;
    phase   = 2;
    for (int k = 0; k < FLOWS; k++) refill[k] = 5;
    step(12);
    check_eq("L1 stalled reads", 64'(g_env[0].bp_reads), 64'(3));
    check_eq("L2 stalled reads", 64'(g_env[1].bp_reads), 64'(4));
    phase   = 0;
    dst_rdy = 1'b1;
    step(40);

    // reset one cycle after a read is issued
    refill[0] = 1;
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(8);

    // wrap and skip from LAST = FLOWS-1 with flows 1 and 3 populated
    refill[1] = 2;
    refill[3] = 2;
    step(12);

    repeat (2000) begin
      dst_rdy = ($urandom_range(0, 9) < 7);
      rst_n   = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < FLOWS; k++)
        if ($urandom_range(0, 7) == 0) refill[k] = $urandom_range(1, 4);
      step(1);
    end

    rst_n   = 1'b1;
    dst_rdy = 1'b1;
    step(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
